// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state encoding and sizing helpers for the data-memory responder
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_DEPTH_WORDS = 1024;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int word_index_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM with byte-lane write enables and registered read
module dmem_ram
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  localparam int LANES = lane_count(DATA_WIDTH),
  localparam int INDEX_WIDTH = word_index_width(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic [LANES-1:0]       wstrb,
  output logic [DATA_WIDTH-1:0]  rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // rdata only moves on a read access, so it holds while a response waits.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (wstrb[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[index];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder for the pipeline memory stage
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err
);

  localparam int LANES = lane_count(DATA_WIDTH);
  localparam int IW = word_index_width(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  state_t                   state;
  logic [CW-1:0]            count;
  logic                     cap_write;
  logic [ADDRESS_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0]    cap_wdata;
  logic [LANES-1:0]         cap_wstrb;
  logic                     load_ok;
  logic [DATA_WIDTH-1:0]    ram_rdata;

  logic                     accept;
  logic                     commit;
  logic                     c_write;
  logic [ADDRESS_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0]    c_wdata;
  logic [LANES-1:0]         c_wstrb;
  logic                     c_err;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With single-cycle latency the commit edge is the accept edge, so the live request is used.
  assign c_write = (LATENCY == 1) ? req_write : cap_write;
  assign c_addr  = (LATENCY == 1) ? req_addr  : cap_addr;
  assign c_wdata = (LATENCY == 1) ? req_wdata : cap_wdata;
  assign c_wstrb = (LATENCY == 1) ? req_wstrb : cap_wstrb;
  assign commit  = (LATENCY == 1) ? accept : (state == WAIT && count == CW'(1) && !rst);

  // Full-width range check: any address bit above the word index flags an error, no aliasing.
  assign c_err = (c_addr[1:0] != 2'b00) || (|c_addr[ADDRESS_WIDTH-1:IW+2]);

  assign resp_rdata = load_ok ? ram_rdata : '0;

  dmem_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk(clk),
    .en(commit && !c_err),
    .we(c_write),
    .index(c_addr[IW+1:2]),
    .wdata(c_wdata),
    .wstrb(c_wstrb),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      load_ok    <= 1'b0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_wstrb <= req_wstrb;
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= c_err;
              load_ok    <= !c_write && !c_err;
            end else begin
              state <= WAIT;
              count <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= c_err;
            load_ok    <= !c_write && !c_err;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            load_ok    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at latencies 2, 1 and 4
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a  [3];
  logic        req_ready_a  [3];
  logic        req_write_a  [3];
  logic [31:0] req_addr_a   [3];
  logic [31:0] req_wdata_a  [3];
  logic [3:0]  req_wstrb_a  [3];
  logic        resp_valid_a [3];
  logic        resp_ready_a [3];
  logic [31:0] resp_rdata_a [3];
  logic        resp_err_a   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]), .req_write(req_write_a[0]),
    .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]), .req_wstrb(req_wstrb_a[0]),
    .resp_valid(resp_valid_a[0]), .resp_ready(resp_ready_a[0]),
    .resp_rdata(resp_rdata_a[0]), .resp_err(resp_err_a[0])
  );

  dmem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]), .req_write(req_write_a[1]),
    .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]), .req_wstrb(req_wstrb_a[1]),
    .resp_valid(resp_valid_a[1]), .resp_ready(resp_ready_a[1]),
    .resp_rdata(resp_rdata_a[1]), .resp_err(resp_err_a[1])
  );

  dmem_responder #(.LATENCY(4)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]), .req_write(req_write_a[2]),
    .req_addr(req_addr_a[2]), .req_wdata(req_wdata_a[2]), .req_wstrb(req_wstrb_a[2]),
    .resp_valid(resp_valid_a[2]), .resp_ready(resp_ready_a[2]),
    .resp_rdata(resp_rdata_a[2]), .resp_err(resp_err_a[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with resp_ready held high; lat is 1 when resp_valid is seen right after the accept edge.
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic er, output int lat);
    int n;
    req_write_a[k] = w;
    req_addr_a[k]  = a;
    req_wdata_a[k] = d;
    req_wstrb_a[k] = s;
    req_valid_a[k] = 1'b1;
    resp_ready_a[k] = 1'b1;
    n = 0;
    while (!req_ready_a[k] && n < 20) begin tick(); n++; end
    tick();
    req_valid_a[k] = 1'b0;
    lat = 1;
    while (!resp_valid_a[k] && lat < 20) begin tick(); lat++; end
    rd = resp_rdata_a[k];
    er = resp_err_a[k];
    tick();
  endtask

  task automatic tput(input int k, input int expv, input string tag);
    int hits[$];
    int g1, g2;
    req_write_a[k]  = 1'b0;
    req_addr_a[k]   = 32'h10;
    req_valid_a[k]  = 1'b1;
    resp_ready_a[k] = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (req_ready_a[k]) hits.push_back(c);
      tick();
    end
    req_valid_a[k] = 1'b0;
    repeat (8) tick();
    chk({tag, "_accepts"}, 32'(hits.size() >= 3), 32'd1);
    g1 = (hits.size() >= 3) ? hits[1] - hits[0] : -1;
    g2 = (hits.size() >= 3) ? hits[2] - hits[1] : -1;
    chk({tag, "_gap1"}, g1, expv);
    chk({tag, "_gap2"}, g2, expv);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    int n;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid_a[k] = 1'b0; req_write_a[k] = 1'b0; req_addr_a[k] = '0;
      req_wdata_a[k] = '0;   req_wstrb_a[k] = '0;   resp_ready_a[k] = 1'b1;
    end
    repeat (2) tick();
    chk("rst_req_ready", req_ready_a[0], 0);
    chk("rst_resp_valid", resp_valid_a[0], 0);
    chk("rst_resp_rdata", resp_rdata_a[0], 0);
    chk("rst_resp_err", resp_err_a[0], 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready0", req_ready_a[0], 1);
    chk("post_rst_ready2", req_ready_a[2], 1);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("st10_lat", lat, 2);
    chk("st10_err", er, 0);
    chk("st10_rdata", rd, 0);
    chk("st10_idle_ready", req_ready_a[0], 1);
    chk("st10_valid_drop", resp_valid_a[0], 0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("ld10_lat", lat, 2);
    chk("ld10_rdata", rd, 32'hDEADBEEF);
    chk("ld10_err", er, 0);

    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("partial_rdata", rd, 32'h11BB33DD);
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    chk("nostrb_err", er, 0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("nostrb_rdata", rd, 32'h11BB33DD);

    txn(0, 1'b1, 32'hFFC, 32'h5A5AA5A5, 4'hF, rd, er, lat);
    chk("topword_st_err", er, 0);
    txn(0, 1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
    chk("topword_ld_rdata", rd, 32'h5A5AA5A5);
    chk("topword_ld_err", er, 0);

    txn(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat);
    txn(0, 1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    chk("misalign_err", er, 1);
    chk("misalign_rdata", rd, 0);
    txn(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    chk("range_err", er, 1);
    chk("range_rdata", rd, 0);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("noalias_rdata", rd, 32'h0BADF00D);
    chk("noalias_err", er, 0);

    // backpressure: a second request stays pending while the response is held
    req_write_a[0] = 1'b0; req_addr_a[0] = 32'h10; req_valid_a[0] = 1'b1; resp_ready_a[0] = 1'b0;
    tick();
    req_write_a[0] = 1'b1; req_wdata_a[0] = 32'h0; req_wstrb_a[0] = 4'hF;
    n = 0;
    while (!resp_valid_a[0] && n < 20) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", resp_valid_a[0], 1);
      chk("bp_rdata", resp_rdata_a[0], 32'hDEADBEEF);
      chk("bp_err", resp_err_a[0], 0);
      chk("bp_req_ready", req_ready_a[0], 0);
      tick();
    end
    resp_ready_a[0] = 1'b1;
    tick();
    req_valid_a[0] = 1'b0;
    chk("bp_release_valid", resp_valid_a[0], 0);
    chk("bp_release_ready", req_ready_a[0], 1);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("bp_unwritten", rd, 32'hDEADBEEF);

    txn(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd, er, lat);
    req_write_a[0] = 1'b1; req_addr_a[0] = 32'h40; req_wdata_a[0] = 32'h12345678;
    req_wstrb_a[0] = 4'hF; req_valid_a[0] = 1'b1;
    tick();
    req_valid_a[0] = 1'b0;
    chk("midrst_accepted", req_ready_a[0], 0);
    rst = 1'b1;
    #1;
    chk("midrst_idle_ready_in_rst", req_ready_a[1], 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_valid", resp_valid_a[0], 0);
    chk("midrst_ready", req_ready_a[0], 1);
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("midrst_old_value", rd, 32'hCAFEF00D);

    txn(1, 1'b1, 32'h10, 32'h01010101, 4'hF, rd, er, lat);
    chk("l1_st_lat", lat, 1);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("l1_ld_lat", lat, 1);
    chk("l1_ld_rdata", rd, 32'h01010101);
    txn(2, 1'b1, 32'h10, 32'h02020202, 4'hF, rd, er, lat);
    chk("l4_st_lat", lat, 4);
    txn(2, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("l4_ld_lat", lat, 4);
    chk("l4_ld_rdata", rd, 32'h02020202);

    tput(1, 2, "l1_tput");
    tput(2, 5, "l4_tput");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
